// File: rtl/s9234_n311_bist_tpg.sv
// BIST source and compactor for the s9234 n311 cone: a 23-bit Fibonacci LFSR
// drives the cone inputs and a 16-bit serial signature folds the n311 response.
module s9234_n311_bist_tpg #(
   parameter int unsigned N_PAT    = 1024,
   parameter logic [22:0] SEED_RST = 23'h000001,
   parameter logic [15:0] SIG_POLY = 16'h1021
) (
   input  logic        CK,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        seed_load,
   input  logic [22:0] seed_in,
   output logic [22:0] pat,
   output logic        pat_valid,
   input  logic        resp_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] sig
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [15:0] LAST_CNT = 16'(N_PAT - 1);

   state_t      state_q;
   logic [22:0] seed_q;
   logic [22:0] seed_d;
   logic [22:0] lfsr_q;
   logic [22:0] lfsr_d;
   logic [15:0] sig_q;
   logic [15:0] sig_d;
   logic [15:0] count_q;
   logic        pv_q;
   logic        busy_q;
   logic        done_q;

   // An all-zero LFSR state would never leave zero, so zero maps to 1.
   function automatic logic [22:0] nz_seed(input logic [22:0] s);
      return (s == 23'h000000) ? 23'h000001 : s;
   endfunction

   function automatic logic [22:0] lfsr_step(input logic [22:0] l);
      return {l[21:0], l[22] ^ l[17]};
   endfunction

   function automatic logic [15:0] sig_step(input logic [15:0] s, input logic r);
      return {s[14:0], 1'b0} ^ ((s[15] ^ r) ? SIG_POLY : 16'h0000);
   endfunction

   always_comb begin
      lfsr_d = lfsr_step(lfsr_q);
      sig_d  = sig_step(sig_q, resp_in);
      seed_d = seed_load ? nz_seed(seed_in) : seed_q;
   end

   always_ff @(posedge CK) begin
      if (reset) begin
         state_q <= IDLE;
         seed_q  <= nz_seed(SEED_RST);
         lfsr_q  <= nz_seed(SEED_RST);
         sig_q   <= 16'h0000;
         count_q <= 16'h0000;
         pv_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               seed_q <= seed_d;
               if (start) begin
                  // seed_d already carries a same-cycle seed_load
                  lfsr_q  <= seed_d;
                  sig_q   <= 16'h0000;
                  count_q <= 16'h0000;
                  state_q <= RUN;
                  pv_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            RUN: begin
               if (abort) begin
                  state_q <= IDLE;
                  pv_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end else begin
                  lfsr_q  <= lfsr_d;
                  sig_q   <= sig_d;
                  count_q <= count_q + 16'd1;
                  if (count_q == LAST_CNT) begin
                     state_q <= DONE;
                     pv_q    <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               pv_q    <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pat       = lfsr_q;
   assign pat_valid = pv_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sig       = sig_q;

endmodule

// File: doc/s9234_n311_bist_tpg.md
Name: s9234_n311_bist_tpg

Overview:
- Sequential test-pattern source and response compactor for the combinational n311 cone of s9234.
- Drives the cone's 23 primary inputs from a maximal-length LFSR and takes the cone's n311 response back.
- Compacts the responses into a 16-bit serial signature and reports it after a programmable number of patterns.
- Sits beside the cone in the reliability-estimation harness. It is the transmitting/checking end for the cone's inputs and output.

Parameters:
- N_PAT, 1024: patterns per run; legal range 1..65535.
- SEED_RST, 23'h000001: LFSR seed after reset.
- SIG_POLY, 16'h1021: signature feedback taps, x^16+x^12+x^5+1.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a run; honoured only in IDLE or DONE.
- abort  input  1  terminate a run; honoured only in RUN.
- seed_load  input  1  load seed_in into the seed register; honoured only in IDLE or DONE.
- seed_in  input  23  new seed value.
- pat  output  23  cone input vector. Bit order pat[0..22] = g314,g301,g306,g310,g361,g319,g366,g79,g84,g323,g332,g345,g349,g338,g341,g357,g353,g59,g54,g49,g69,g74,g64.
- pat_valid  output  1  pat is a live test pattern this cycle.
- resp_in  input  1  n311 returned from the cone; combinational, same cycle as pat.
- busy  output  1  state == RUN.
- done  output  1  state == DONE; sig is final.
- sig  output  16  signature register.

Behaviour:
- Reset (synchronous, active-high), wins over all other inputs:
  - state IDLE; seed register SEED_RST; lfsr SEED_RST; pat SEED_RST.
  - sig 0, count 0, pat_valid 0, busy 0, done 0.
- pat is the lfsr register directly, so there is no combinational path from inputs to pat.
- LFSR step (Fibonacci, x^23+x^18+1): lfsr <= {lfsr[21:0], lfsr[22]^lfsr[17]}.
- Zero-seed guard: a seed of 0 is stored as 23'h000001, so the LFSR can never lock up.
- Signature step: fb = sig[15]^resp_in; sig <= {sig[14:0],1'b0} ^ (fb ? SIG_POLY : 0).
- count is 16 bits.
- States:
  - IDLE:
    - seed_load: seed <= seed_in, with the zero guard.
    - start: lfsr <= seed, sig <= 0, count <= 0, go to RUN.
    - If seed_load and start occur in the same cycle, start uses the new seed_in value.
  - RUN:
    - pat_valid = 1.
    - Each edge: sample resp_in into sig, advance lfsr, count++.
    - On the edge where count == N_PAT-1: go to DONE. The lfsr advances once more; its value is don't-care.
    - pat_valid is high for exactly N_PAT consecutive cycles. The first pattern is the seed.
    - start and seed_load are ignored.
  - abort in RUN:
    - Go to IDLE; sig and count freeze at their current values.
    - done stays 0; that edge does not sample resp_in.
    - abort outside RUN is ignored.
  - DONE:
    - done = 1; sig is held; pat_valid = 0.
    - Behaves like IDLE for start and seed_load. start re-seeds, clears sig, drops done on the next edge, and enters RUN.
- Latency: start sampled at edge k gives pat_valid = 1 from edge k. done rises at edge k+N_PAT.
- Simultaneous reset with anything: reset only. Reset mid-RUN discards the run.

Test Plan:
- Reset, then idle 3 cycles -> pat=23'h000001, pat_valid=0, busy=0, done=0, sig=16'h0000.
- Default seed, start, resp_in=0 -> pat sequence 000001, 000002, 000004, …; pattern 17 = 23'h020000, pattern 18 = 23'h040001. After N_PAT cycles: done=1, sig=16'h0000, pat_valid high exactly N_PAT cycles.
- N_PAT=2; resp_in=1 on pattern 0, 0 on pattern 1 -> sig after the first edge 16'h1021, final sig 16'h2042, done=1 two cycles after start.
- seed_load with seed_in=0 in IDLE, then start -> first pattern 23'h000001. seed_load asserted during RUN -> ignored; the next run in DONE uses the old seed.
- N_PAT=8, abort at pattern 3 -> next cycle IDLE, busy=0, done=0, sig frozen, pat_valid=0. A later start restarts from the seed with sig cleared.
- start held high through RUN into DONE -> a second run begins one cycle after done rises. done=1 for exactly one cycle, and the second signature equals the first for identical resp_in.
